cim_vector_datapath: RTL and testbench

Parametrised successor to the single-row CIM datapath. It accepts one command at a time over a valid/ready interface, then walks `len+1` consecutive SRAM rows. For each row it reads two operands from the dual-port array, applies the per-lane bitline op and the read-stage op, and writes the result back to a destination row. Its new capabilities are a multi-row vector mode and bit-serial transposed ADD/SUB with a carry register that persists across rows. It sits between the instruction sequencer and the dual-port SRAM emulation.

---
 rtl/cim_vector_datapath.sv | 169 ++++++++++++++++
 tb/tb_cim_vector_datapath.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_vector_datapath.sv
// rtl/cim_vector_datapath.sv - multi-row CIM vector datapath with bit-serial ADD/SUB
// Walks len+1 SRAM rows per command: read A/B rows, apply lane and read-stage ops, write back.
module cim_vector_datapath #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int ADDR_WIDTH  = 9,
  parameter  int LEN_WIDTH   = 8,
  localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                    sys_clk_in,
  input  logic                    sys_reset_n_in,
  input  logic                    cmd_valid_in,
  output logic                    cmd_ready_out,
  input  logic [3:0]              cmd_op_in,
  input  logic [2*DATA_WIDTH-1:0] cmd_lane_sel_in,
  input  logic [ADDR_WIDTH-1:0]   cmd_src_a_in,
  input  logic [ADDR_WIDTH-1:0]   cmd_src_b_in,
  input  logic [ADDR_WIDTH-1:0]   cmd_dst_in,
  input  logic [LEN_WIDTH-1:0]    cmd_len_in,
  input  logic [SHIFT_WIDTH-1:0]  cmd_shift_in,
  input  logic [DATA_WIDTH-1:0]   cmd_mask_in,
  input  logic [DATA_WIDTH-1:0]   cmd_carry_in,
  output logic [ADDR_WIDTH-1:0]   sram_addr_a_out,
  output logic [ADDR_WIDTH-1:0]   sram_addr_b_out,
  output logic [DATA_WIDTH-1:0]   sram_data_a_out,
  output logic                    sram_wren_a_out,
  input  logic [DATA_WIDTH-1:0]   sram_q_a_in,
  input  logic [DATA_WIDTH-1:0]   sram_q_b_in,
  output logic                    done_out,
  output logic                    error_out,
  output logic [DATA_WIDTH-1:0]   carry_out
);

  localparam logic [3:0] OP_MOVE = 4'd0;
  localparam logic [3:0] OP_XRED = 4'd1;
  localparam logic [3:0] OP_ARED = 4'd2;
  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_ADD  = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WB, S_DONE} state_t;

  state_t                  state;
  logic [3:0]              op_q;
  logic [2*DATA_WIDTH-1:0] sel_q;
  logic [ADDR_WIDTH-1:0]   src_a_q, src_b_q, dst_q;
  logic [LEN_WIDTH-1:0]    len_q, idx_q;
  logic [SHIFT_WIDTH-1:0]  shift_q;
  logic [DATA_WIDTH-1:0]   mask_q, carry_q;
  logic [DATA_WIDTH-1:0]   lane_res, b_eff, carry_nxt, result;
  logic [LEN_WIDTH-1:0]    idx_next;

  function automatic logic op_legal(input logic [3:0] op);
    return op inside {OP_MOVE, OP_XRED, OP_ARED, OP_SHL, OP_SHR, OP_NOT, OP_ADD, OP_SUB};
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] row_addr(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [LEN_WIDTH-1:0]  idx);
    return base + ADDR_WIDTH'(idx);
  endfunction

  assign idx_next = idx_q + 1'b1;
  assign carry_out = carry_q;

  always_comb begin
    lane_res = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      case (sel_q[2*j +: 2])
        2'd0:    lane_res[j] = sram_q_a_in[j] | sram_q_b_in[j];
        2'd1:    lane_res[j] = sram_q_a_in[j] & sram_q_b_in[j];
        2'd2:    lane_res[j] = sram_q_a_in[j] ^ sram_q_b_in[j];
        default: lane_res[j] = sram_q_a_in[j];
      endcase
    end
    // SUB is ADD of the inverted B plane; the all-ones initial carry supplies the +1
    b_eff     = (op_q == OP_SUB) ? ~sram_q_b_in : sram_q_b_in;
    carry_nxt = (sram_q_a_in & b_eff) | (carry_q & (sram_q_a_in ^ b_eff));
    case (op_q)
      OP_MOVE: result = lane_res;
      OP_XRED: result = {{(DATA_WIDTH-1){1'b0}}, ^lane_res};
      OP_ARED: result = {{(DATA_WIDTH-1){1'b0}}, &(lane_res | ~mask_q)};
      OP_SHL:  result = lane_res << shift_q;
      OP_SHR:  result = lane_res >> shift_q;
      OP_NOT:  result = ~lane_res;
      OP_ADD,
      OP_SUB:  result = sram_q_a_in ^ b_eff ^ carry_q;
      default: result = '0;
    endcase
  end

  // Read data only arrives in the WB cycle, so write data is combinational and gated by wren
  assign sram_data_a_out = sram_wren_a_out ? result : '0;

  always_ff @(posedge sys_clk_in or negedge sys_reset_n_in) begin
    if (!sys_reset_n_in) begin
      state           <= S_IDLE;
      op_q            <= '0;
      sel_q           <= '0;
      src_a_q         <= '0;
      src_b_q         <= '0;
      dst_q           <= '0;
      len_q           <= '0;
      idx_q           <= '0;
      shift_q         <= '0;
      mask_q          <= '0;
      carry_q         <= '0;
      sram_addr_a_out <= '0;
      sram_addr_b_out <= '0;
      sram_wren_a_out <= 1'b0;
      cmd_ready_out   <= 1'b1;
      done_out        <= 1'b0;
      error_out       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid_in) begin
            op_q          <= cmd_op_in;
            sel_q         <= cmd_lane_sel_in;
            src_a_q       <= cmd_src_a_in;
            src_b_q       <= cmd_src_b_in;
            dst_q         <= cmd_dst_in;
            len_q         <= cmd_len_in;
            shift_q       <= cmd_shift_in;
            mask_q        <= cmd_mask_in;
            idx_q         <= '0;
            cmd_ready_out <= 1'b0;
            if (cmd_op_in == OP_ADD) carry_q <= cmd_carry_in;
            if (cmd_op_in == OP_SUB) carry_q <= '1;
            if (op_legal(cmd_op_in)) begin
              sram_addr_a_out <= cmd_src_a_in;
              sram_addr_b_out <= cmd_src_b_in;
              state           <= S_RD;
            end else begin
              done_out  <= 1'b1;
              error_out <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_RD: begin
          sram_addr_a_out <= row_addr(dst_q, idx_q);
          sram_wren_a_out <= 1'b1;
          state           <= S_WB;
        end
        S_WB: begin
          sram_wren_a_out <= 1'b0;
          if (op_q == OP_ADD || op_q == OP_SUB) carry_q <= carry_nxt;
          if (idx_q == len_q) begin
            done_out <= 1'b1;
            state    <= S_DONE;
          end else begin
            idx_q           <= idx_next;
            sram_addr_a_out <= row_addr(src_a_q, idx_next);
            sram_addr_b_out <= row_addr(src_b_q, idx_next);
            state           <= S_RD;
          end
        end
        default: begin
          done_out      <= 1'b0;
          error_out     <= 1'b0;
          cmd_ready_out <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cim_vector_datapath.sv
// tb/tb_cim_vector_datapath.sv - self-checking bench for cim_vector_datapath
// Dual-port SRAM model plus a shadow-memory reference computed from the op rules.
module tb_cim_vector_datapath;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int LW = 8;
  localparam int SW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [3:0]      cmd_op = '0;
  logic [2*DW-1:0] cmd_sel = '0;
  logic [AW-1:0]   cmd_sa = '0, cmd_sb = '0, cmd_dst = '0;
  logic [LW-1:0]   cmd_len = '0;
  logic [SW-1:0]   cmd_shift = '0;
  logic [DW-1:0]   cmd_mask = '0, cmd_cin = '0;
  logic [AW-1:0]   addr_a, addr_b;
  logic [DW-1:0]   data_a, q_a = '0, q_b = '0, carry;
  logic            wren, done, err;

  logic [DW-1:0]   mem [0:511];
  logic [DW-1:0]   ref_mem [0:511];
  logic            pk_en = 1'b0;
  logic [AW-1:0]   pk_addr = '0;
  logic [DW-1:0]   pk_data = '0;
  logic [DW-1:0]   exp_carry = '0;
  int              cyc = 0;
  int              n_checks = 0;
  int              n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pk_en) mem[pk_addr] <= pk_data;
    else if (wren) mem[addr_a] <= data_a;
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end

  cim_vector_datapath dut (
    .sys_clk_in(clk), .sys_reset_n_in(rst_n),
    .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready),
    .cmd_op_in(cmd_op), .cmd_lane_sel_in(cmd_sel),
    .cmd_src_a_in(cmd_sa), .cmd_src_b_in(cmd_sb), .cmd_dst_in(cmd_dst),
    .cmd_len_in(cmd_len), .cmd_shift_in(cmd_shift),
    .cmd_mask_in(cmd_mask), .cmd_carry_in(cmd_cin),
    .sram_addr_a_out(addr_a), .sram_addr_b_out(addr_b),
    .sram_data_a_out(data_a), .sram_wren_a_out(wren),
    .sram_q_a_in(q_a), .sram_q_b_in(q_b),
    .done_out(done), .error_out(err), .carry_out(carry)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    pk_en = 1'b1; pk_addr = a; pk_data = v;
    ref_mem[a] = v;
    @(posedge clk);
    #1 pk_en = 1'b0;
  endtask

  function automatic logic [DW-1:0] ref_row(input logic [3:0] op, input logic [2*DW-1:0] sel,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input int sh, input logic [DW-1:0] mask);
    logic [DW-1:0] l;
    for (int j = 0; j < DW; j++) begin
      case (2 * sel[2*j+1] + sel[2*j])
        0: l[j] = a[j] | b[j];
        1: l[j] = a[j] & b[j];
        2: l[j] = a[j] ^ b[j];
        default: l[j] = a[j];
      endcase
    end
    case (op)
      4'd0: return l;
      4'd1: return (^l) ? 32'd1 : 32'd0;
      4'd2: return ((l | ~mask) == '1) ? 32'd1 : 32'd0;
      4'd3: return l << sh;
      4'd4: return l >> sh;
      default: return ~l;
    endcase
  endfunction

  // Applies the command to the shadow memory: row by row for lane ops, lane-wise integer
  // arithmetic over bit planes for ADD/SUB. Returns whether the opcode is legal.
  function automatic logic model(input logic [3:0] op, input logic [2*DW-1:0] sel,
                                 input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                                 input logic [AW-1:0] d, input int len, input int sh,
                                 input logic [DW-1:0] mask, input logic [DW-1:0] cin);
    int n;
    logic [63:0] av, bv, s;
    n = len + 1;
    if (op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7}) begin
      for (int i = 0; i < n; i++)
        ref_mem[AW'(d + i)] = ref_row(op, sel, ref_mem[AW'(sa + i)], ref_mem[AW'(sb + i)], sh, mask);
      return 1'b1;
    end
    if (op == 4'd8 || op == 4'd9) begin
      for (int j = 0; j < DW; j++) begin
        av = '0; bv = '0;
        for (int i = 0; i < n; i++) begin
          av[i] = ref_mem[AW'(sa + i)][j];
          bv[i] = ref_mem[AW'(sb + i)][j];
        end
        if (op == 4'd9) s = av + ((~bv) & ((64'd1 << n) - 1)) + 64'd1;
        else            s = av + bv + {63'd0, cin[j]};
        for (int i = 0; i < n; i++) ref_mem[AW'(d + i)][j] = s[i];
        exp_carry[j] = s[n];
      end
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic run_cmd(input logic [3:0] op, input logic [2*DW-1:0] sel,
                         input logic [AW-1:0] sa, input logic [AW-1:0] sb, input logic [AW-1:0] d,
                         input int len, input int sh, input logic [DW-1:0] mask,
                         input logic [DW-1:0] cin);
    int t, k, wcount, wfirst, wlast, done_at;
    logic legal, got_err;
    legal = model(op, sel, sa, sb, d, len, sh, mask, cin);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_sa = sa; cmd_sb = sb; cmd_dst = d;
    cmd_len = LW'(len); cmd_shift = SW'(sh); cmd_mask = mask; cmd_cin = cin;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    check("ready_wait", 64'(cmd_ready), 64'd1);
    t = cyc;
    wcount = 0; wfirst = -1; wlast = -1; done_at = -1; got_err = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      if (wren) begin
        wcount++;
        if (wfirst < 0) wfirst = cyc - t;
        wlast = cyc - t;
      end
      if (done) begin done_at = cyc - t; got_err = err; break; end
    end
    check("done_cycle", 64'(done_at), legal ? 64'(3 + 2 * len) : 64'd1);
    check("error", 64'(got_err), legal ? 64'd0 : 64'd1);
    check("wren_count", 64'(wcount), legal ? 64'(len + 1) : 64'd0);
    if (legal) begin
      check("wren_first", 64'(wfirst), 64'd2);
      check("wren_last", 64'(wlast), 64'(2 + 2 * len));
      for (int i = 0; i <= len; i++) check("dst_row", 64'(mem[AW'(d + i)]), 64'(ref_mem[AW'(d + i)]));
    end
    check("carry", 64'(carry), 64'(exp_carry));
    @(negedge clk);
    check("ready_after", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    int ops [10] = '{0, 1, 2, 3, 4, 7, 8, 9, 5, 12};
    int t, dcount, bad, len;
    logic [3:0] op;
    logic [AW-1:0] sa, sb, d;

    repeat (2) @(negedge clk);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_wren", 64'(wren), 64'd0);
    check("rst_addr", 64'({addr_a, addr_b}), 64'd0);
    check("rst_data", 64'(data_a), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 512; i++) poke(AW'(i), $urandom);

    // MOVE with XOR lanes
    poke(9'd10, 32'hF0F0_F0F0); poke(9'd20, 32'hFF00_FF00);
    run_cmd(4'd0, {DW{2'b10}}, 9'd10, 9'd20, 9'd30, 0, 0, '0, '0);
    check("move_dst", 64'(mem[30]), 64'h0FF0_0FF0);

    // Bit-plane ADD 5+3 and SUB in both directions
    for (int i = 0; i < 4; i++) begin
      poke(AW'(40 + i), (i == 0 || i == 2) ? 32'd1 : 32'd0);
      poke(AW'(50 + i), (i < 2) ? 32'd1 : 32'd0);
    end
    run_cmd(4'd8, '0, 9'd40, 9'd50, 9'd60, 3, 0, '0, '0);
    for (int i = 0; i < 4; i++) check("add_row", 64'(mem[60 + i]), (i == 3) ? 64'd1 : 64'd0);
    check("add_carry0", 64'(carry[0]), 64'd0);
    run_cmd(4'd9, '0, 9'd40, 9'd50, 9'd70, 3, 0, '0, '0);
    for (int i = 0; i < 4; i++) check("sub_row", 64'(mem[70 + i]), (i == 1) ? 64'd1 : 64'd0);
    check("sub_carry0", 64'(carry[0]), 64'd1);
    run_cmd(4'd9, '0, 9'd50, 9'd40, 9'd80, 3, 0, '0, '0);
    for (int i = 0; i < 4; i++) check("subn_row", 64'(mem[80 + i]), (i == 0) ? 64'd0 : 64'd1);
    check("subn_carry0", 64'(carry[0]), 64'd0);

    // AND reduction with masks, SHR across the address wrap
    poke(9'd90, 32'h0000_FFFF);
    run_cmd(4'd2, '1, 9'd90, 9'd90, 9'd91, 0, 0, 32'h0000_FFFF, '0);
    check("ared_full", 64'(mem[91]), 64'd1);
    run_cmd(4'd2, '1, 9'd90, 9'd90, 9'd92, 0, 0, 32'h0001_FFFF, '0);
    check("ared_miss", 64'(mem[92]), 64'd0);
    poke(9'h1FF, 32'h8000_0000);
    run_cmd(4'd4, '1, 9'h1FF, 9'd5, 9'd100, 1, 31, '0, '0);
    check("shr_dst", 64'(mem[100]), 64'd1);

    run_cmd(4'd5, $urandom, 9'd3, 9'd4, 9'd110, 2, 0, '0, '0);

    for (int it = 0; it < 40; it++) begin
      op = 4'(ops[$urandom_range(0, 9)]);
      if (op == 4'd8 || op == 4'd9) begin
        sa = AW'($urandom_range(0, 127));
        sb = AW'($urandom_range(128, 255));
        d = ($urandom_range(0, 3) == 0) ? sa : AW'($urandom_range(256, 383));
        len = $urandom_range(0, 15);
      end else begin
        sa = AW'($urandom); sb = AW'($urandom); d = AW'($urandom);
        len = $urandom_range(0, 7);
      end
      run_cmd(op, {$urandom, $urandom}, sa, sb, d, len, $urandom_range(0, 31), $urandom, $urandom);
    end

    // Reset in the middle of a long ADD: row 0 lands, nothing after it
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd8; cmd_sa = 9'd200; cmd_sb = 9'd220; cmd_dst = 9'd240;
    cmd_len = 8'd7; cmd_cin = $urandom;
    check("rst_test_ready", 64'(cmd_ready), 64'd1);
    t = cyc;
    while (cyc - t < 4) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    check("mid_wren", 64'(wren), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wren", 64'(wren), 64'd0);
    check("mid_rst_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_carry", 64'(carry), 64'd0);
    ref_mem[240] = ref_mem[200] ^ ref_mem[220] ^ cmd_cin;
    exp_carry = '0;
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("no_done_after_rst", 64'(dcount), 64'd0);
    check("ready_after_rst", 64'(cmd_ready), 64'd1);
    check("rst_row0", 64'(mem[240]), 64'(ref_mem[240]));
    check("rst_row1", 64'(mem[241]), 64'(ref_mem[241]));

    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_all", 64'(bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
